shufflenet_mem_ctrl: RTL and testbench
======================================

# shufflenet_mem_ctrl

Memory-controller responder for the ShuffleNet core: it serves the core's per-cycle read, kernel and write requests out of two ping-pong feature RAMs (A/B) and one weight ROM. It also loads a full MFSC frame into RAM A before each inference and starts the core. It sits between the MFSC front end, the on-chip RAM macros and the ShuffleNet datapath/FSM.

## Interface
Parameters:
- ADDR_W, 12, feature RAM address width (64-bit words)
- W_ADDR_W, 10, weight ROM address width (320-bit words)
- FRAME_WORDS, 400, MFSC words loaded per inference

Ports:
- CLK  in  1  clock; all logic rising-edge
- RST  in  1  asynchronous, active-high reset
- mfsc_valid  in  1  MFSC word present
- mfsc_data  in  64  MFSC word
- mfsc_ready  out  1  controller accepting MFSC words
- MFSC_Ready  out  1  one-cycle start pulse to core
- Stage, next_Stage  in  6  core current / next-cycle stage
- Input_Require_WP  in  1  core needs inA/inB next cycle
- Kernel_Require  in  1  core needs weight_bus next cycle
- Write_Require  in  1  core drives out_bus next cycle
- Result_Ready  in  1  inference complete
- out_bus  in  64  core write data
- inA_bus, inB_bus  out  64  core read data
- weight_bus  out  320  core weights
- ramA_waddr, ramA_raddr, ramB_waddr, ramB_raddr  out  ADDR_W  simple-dual-port RAM addresses
- ramA_we, ramB_we  out  1  write enables
- ramA_wdata, ramB_wdata  out  64  write data
- ramA_rdata, ramB_rdata  in  64  read data (1-cycle sync read)
- w_addr  out  W_ADDR_W  weight ROM address
- w_rdata  in  320  weight data (1-cycle sync read)

## Operation
- FSM states: LOAD, START, RUN.
  - LOAD: mfsc_ready=1. Each mfsc_valid cycle writes mfsc_data to RAM A at ld_cnt, then ld_cnt++. When the write at ld_cnt==FRAME_WORDS-1 completes, go to START.
  - START: MFSC_Ready=1 for exactly one cycle, then go to RUN.
  - RUN: serve requests. Result_Ready=1 sends the FSM to LOAD, clearing ld_cnt, rd_cnt, wr_cnt and w_cnt.
- Direction: src/dst is taken from next_Stage[0] in the request cycle.
  - Even stage: src=A, dst=B.
  - Odd stage: src=B, dst=A.
- inB_bus is always sourced from RAM B.
- Stage boundary: stage_chg = (next_Stage != Stage). The effective counter = stage_chg ? 0 : counter. This applies to rd_cnt and wr_cnt.
- Read request (RUN, Input_Require_WP=1):
  - src raddr and ramB_raddr = effective rd_cnt.
  - rd_cnt <= effective rd_cnt + 1. With no request, rd_cnt <= effective value.
- Write request (RUN, Write_Require=1): latch dst and effective wr_cnt. In the next cycle, assert dst we with wdata=out_bus at the latched address; wr_cnt <= effective + 1.
- Kernel request (RUN, Kernel_Require=1): w_addr = w_cnt, w_cnt++. w_cnt is not cleared on stage change (weights stored linearly).
- Counter wrap-around: all counters wrap modulo 2^width. No saturation.
- Requests outside RUN are ignored.

## Timing
- Read latency: a request in cycle t yields data on inA_bus/inB_bus/weight_bus in cycle t+1. The source mux select is registered at t.
- In any cycle not following an accepted request, inA_bus, inB_bus and weight_bus = 0.
- Write: Write_Require at t produces RAM we at t+1 with that cycle's out_bus. A write pending across a stage change uses the direction and address latched at t.
- Simultaneous read of src and write of dst in the same cycle is legal (separate RAMs/ports).
- Reset values: FSM=LOAD, mfsc_ready=1, MFSC_Ready=0, all we=0, all addresses=0, all counters=0, data outputs=0.
- RST asserted mid-RUN aborts immediately: any pending write is dropped and RAM contents are untouched.
- A raddr/w_addr with no request holds its last value (don't care).

## Structure
- Shared package `shufflenet_pkg`: FSM state enum, bus widths (64, 320), the ADDR_W/W_ADDR_W defaults and the stage-parity direction constants.
- One natural sub-module: `pingpong_addr_gen`, holding rd_cnt/wr_cnt, the stage-change reset, the direction select and the write latch. FSM and weight counter stay in the top.

## Test plan
- Load: FRAME_WORDS=4, words 0x11..0x44 with a gap cycle -> RAM A[0..3]=0x11..0x44, MFSC_Ready pulses once, 1 cycle after the last write.
- Stage 0, three Input_Require_WP cycles -> ramA_raddr 0,1,2. inA_bus equals the RAM A data one cycle later; gap cycles give 0.
- Stage 0 → 1 transition with Write_Require at the last stage-0 cycle -> write lands in B at the old address. The next write goes to A at address 0.
- Kernel_Require ×5 spanning a stage change -> w_addr 0..4 continuous, weight_bus valid at t+1.
- RST pulsed during RUN with a write pending -> no we in the next cycle, FSM=LOAD, all counters 0.
- Result_Ready in RUN -> mfsc_ready=1 next cycle. A new load starts at RAM A address 0.

Source files
------------

// File: rtl/shufflenet_pkg.sv
// Shared types and constants for the ShuffleNet memory controller:
// FSM states, bus widths, default address widths and ping-pong direction.
package shufflenet_pkg;

  localparam int DATA_W       = 64;
  localparam int WGT_W        = 320;
  localparam int STAGE_W      = 6;
  localparam int ADDR_W_DEF   = 12;
  localparam int W_ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  typedef enum logic {
    RAM_A = 1'b0,
    RAM_B = 1'b1
  } ram_sel_t;

  // Even stages read A and write B; odd stages swap the roles.
  localparam ram_sel_t SRC_EVEN = RAM_A;
  localparam ram_sel_t SRC_ODD  = RAM_B;

  function automatic ram_sel_t src_of(input logic parity);
    return parity ? SRC_ODD : SRC_EVEN;
  endfunction

  function automatic ram_sel_t other_ram(input ram_sel_t s);
    return (s == RAM_A) ? RAM_B : RAM_A;
  endfunction

endpackage

// File: rtl/shufflenet_mem_ctrl_if.sv
// Core-side and MFSC-side signals of the memory controller, bundled as one interface.
// An MFSC word transfers on a cycle with mfsc_valid && mfsc_ready; core requests are
// single-cycle strobes sampled every cycle, with no back-pressure toward the core.
interface shufflenet_mem_ctrl_if;
  import shufflenet_pkg::*;

  logic                mfsc_valid;
  logic [DATA_W-1:0]   mfsc_data;
  logic                mfsc_ready;
  logic                MFSC_Ready;
  logic [STAGE_W-1:0]  Stage;
  logic [STAGE_W-1:0]  next_Stage;
  logic                Input_Require_WP;
  logic                Kernel_Require;
  logic                Write_Require;
  logic                Result_Ready;
  logic [DATA_W-1:0]   out_bus;
  logic [DATA_W-1:0]   inA_bus;
  logic [DATA_W-1:0]   inB_bus;
  logic [WGT_W-1:0]    weight_bus;

  modport master (
    output mfsc_valid, mfsc_data, Stage, next_Stage, Input_Require_WP,
           Kernel_Require, Write_Require, Result_Ready, out_bus,
    input  mfsc_ready, MFSC_Ready, inA_bus, inB_bus, weight_bus
  );

  modport slave (
    input  mfsc_valid, mfsc_data, Stage, next_Stage, Input_Require_WP,
           Kernel_Require, Write_Require, Result_Ready, out_bus,
    output mfsc_ready, MFSC_Ready, inA_bus, inB_bus, weight_bus
  );

endinterface

// File: rtl/pingpong_addr_gen.sv
// Read/write address counters for the ping-pong feature RAMs: per-stage restart,
// stage-parity direction select and the one-cycle write latch.
module pingpong_addr_gen
  import shufflenet_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               rd_req,
  input  logic               wr_req,
  input  logic [STAGE_W-1:0] stage,
  input  logic [STAGE_W-1:0] next_stage,
  output ram_sel_t           src,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               wr_pend,
  output ram_sel_t           wr_dst,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [ADDR_W-1:0]  rd_cnt,
  output logic [ADDR_W-1:0]  wr_cnt
);

  logic              stage_chg;
  logic [ADDR_W-1:0] eff_wr;

  assign stage_chg = (next_stage != stage);
  assign src       = src_of(next_stage[0]);
  assign rd_addr   = stage_chg ? '0 : rd_cnt;
  assign eff_wr    = stage_chg ? '0 : wr_cnt;

  // The write target is frozen at request time so a write that straddles a
  // stage boundary still lands in the old destination at the old address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      wr_pend <= 1'b0;
      wr_dst  <= RAM_A;
      wr_addr <= '0;
    end else if (clr) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= wr_req;
      if (en) begin
        rd_cnt <= rd_req ? rd_addr + ADDR_W'(1) : rd_addr;
        wr_cnt <= wr_req ? eff_wr + ADDR_W'(1) : eff_wr;
      end
      if (wr_req) begin
        wr_dst  <= other_ram(src);
        wr_addr <= eff_wr;
      end
    end
  end

endmodule

// File: rtl/shufflenet_mem_ctrl.sv
// Memory-controller responder for the ShuffleNet core: loads an MFSC frame into
// RAM A, pulses the core start, then serves read/kernel/write requests.
module shufflenet_mem_ctrl
  import shufflenet_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int W_ADDR_W    = W_ADDR_W_DEF,
  parameter int FRAME_WORDS = 400
) (
  input  logic                CLK,
  input  logic                RST,
  shufflenet_mem_ctrl_if.slave core,
  output logic [ADDR_W-1:0]   ramA_waddr,
  output logic [ADDR_W-1:0]   ramA_raddr,
  output logic [ADDR_W-1:0]   ramB_waddr,
  output logic [ADDR_W-1:0]   ramB_raddr,
  output logic                ramA_we,
  output logic                ramB_we,
  output logic [DATA_W-1:0]   ramA_wdata,
  output logic [DATA_W-1:0]   ramB_wdata,
  input  logic [DATA_W-1:0]   ramA_rdata,
  input  logic [DATA_W-1:0]   ramB_rdata,
  output logic [W_ADDR_W-1:0] w_addr,
  input  logic [WGT_W-1:0]    w_rdata,
  output state_t              dbg_state,
  output logic [ADDR_W-1:0]   dbg_ld_cnt,
  output logic [ADDR_W-1:0]   dbg_rd_cnt,
  output logic [ADDR_W-1:0]   dbg_wr_cnt,
  output logic [W_ADDR_W-1:0] dbg_w_cnt
);

  localparam logic [ADDR_W-1:0] LAST_LD = ADDR_W'(FRAME_WORDS - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     ld_cnt;
  logic [W_ADDR_W-1:0]   w_cnt, w_addr_q;
  logic [ADDR_W-1:0]     raddr_a_q, raddr_b_q;
  logic                  ld_wr, serve, clr;
  logic                  rd_req, wr_req, k_req;
  logic                  rd_vld_q, k_vld_q;
  ram_sel_t              rd_sel_q;
  ram_sel_t              src, wr_dst;
  logic [ADDR_W-1:0]     rd_addr, wr_addr, rd_cnt, wr_cnt;
  logic                  wr_pend, pend_a, pend_b;

  always_comb begin
    state_d         = state_q;
    core.mfsc_ready = 1'b0;
    core.MFSC_Ready = 1'b0;
    ld_wr           = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        core.mfsc_ready = 1'b1;
        ld_wr           = core.mfsc_valid;
        if (ld_wr && (ld_cnt == LAST_LD)) state_d = ST_START;
      end
      ST_START: begin
        core.MFSC_Ready = 1'b1;
        state_d         = ST_RUN;
      end
      ST_RUN: begin
        if (core.Result_Ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // The completion cycle only clears counters; no request is served alongside it.
  assign serve  = (state_q == ST_RUN) && !core.Result_Ready;
  assign clr    = (state_q == ST_RUN) && core.Result_Ready;
  assign rd_req = serve && core.Input_Require_WP;
  assign wr_req = serve && core.Write_Require;
  assign k_req  = serve && core.Kernel_Require;

  pingpong_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (CLK),
    .rst        (RST),
    .en         (serve),
    .clr        (clr),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .stage      (core.Stage),
    .next_stage (core.next_Stage),
    .src        (src),
    .rd_addr    (rd_addr),
    .wr_pend    (wr_pend),
    .wr_dst     (wr_dst),
    .wr_addr    (wr_addr),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_LOAD;
      ld_cnt    <= '0;
      w_cnt     <= '0;
      w_addr_q  <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_sel_q  <= RAM_A;
      k_vld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rd_req;
      k_vld_q  <= k_req;
      if (rd_req) begin
        rd_sel_q  <= src;
        raddr_b_q <= rd_addr;
        if (src == RAM_A) raddr_a_q <= rd_addr;
      end
      if (k_req) w_addr_q <= w_cnt;
      if (clr) begin
        ld_cnt <= '0;
        w_cnt  <= '0;
      end else begin
        if (ld_wr) ld_cnt <= ld_cnt + ADDR_W'(1);
        if (k_req) w_cnt <= w_cnt + W_ADDR_W'(1);
      end
    end
  end

  // Read addresses go out combinationally in the request cycle so the
  // synchronous RAMs return data exactly one cycle later.
  assign ramA_raddr = (rd_req && (src == RAM_A)) ? rd_addr : raddr_a_q;
  assign ramB_raddr = rd_req ? rd_addr : raddr_b_q;
  assign w_addr     = k_req ? w_cnt : w_addr_q;

  assign core.inA_bus    = !rd_vld_q ? '0 : ((rd_sel_q == RAM_B) ? ramB_rdata : ramA_rdata);
  assign core.inB_bus    = rd_vld_q ? ramB_rdata : '0;
  assign core.weight_bus = k_vld_q ? w_rdata : '0;

  assign pend_a     = wr_pend && (wr_dst == RAM_A);
  assign pend_b     = wr_pend && (wr_dst == RAM_B);
  assign ramA_we    = ld_wr || pend_a;
  assign ramA_waddr = ld_wr ? ld_cnt : wr_addr;
  assign ramA_wdata = ld_wr ? core.mfsc_data : (pend_a ? core.out_bus : '0);
  assign ramB_we    = pend_b;
  assign ramB_waddr = wr_addr;
  assign ramB_wdata = pend_b ? core.out_bus : '0;

  assign dbg_state  = state_q;
  assign dbg_ld_cnt = ld_cnt;
  assign dbg_rd_cnt = rd_cnt;
  assign dbg_wr_cnt = wr_cnt;
  assign dbg_w_cnt  = w_cnt;

endmodule

// File: tb/tb_shufflenet_mem_ctrl.sv
// Self-checking bench for shufflenet_mem_ctrl: directed load/read/write/kernel/reset
// steps plus a randomized run, checked against a transaction-level model.
module tb_shufflenet_mem_ctrl;
  import shufflenet_pkg::*;

  localparam int AW  = 12;
  localparam int WAW = 10;
  localparam int FW  = 4;

  logic clk, rst;

  shufflenet_mem_ctrl_if bus();

  logic [AW-1:0]  ramA_waddr, ramA_raddr, ramB_waddr, ramB_raddr;
  logic           ramA_we, ramB_we;
  logic [63:0]    ramA_wdata, ramB_wdata;
  logic [63:0]    ramA_rdata, ramB_rdata;
  logic [WAW-1:0] w_addr;
  logic [319:0]   w_rdata;
  state_t         dbg_state;
  logic [AW-1:0]  dbg_ld_cnt, dbg_rd_cnt, dbg_wr_cnt;
  logic [WAW-1:0] dbg_w_cnt;

  shufflenet_mem_ctrl #(.ADDR_W(AW), .W_ADDR_W(WAW), .FRAME_WORDS(FW)) dut (
    .CLK        (clk),
    .RST        (rst),
    .core       (bus),
    .ramA_waddr (ramA_waddr),
    .ramA_raddr (ramA_raddr),
    .ramB_waddr (ramB_waddr),
    .ramB_raddr (ramB_raddr),
    .ramA_we    (ramA_we),
    .ramB_we    (ramB_we),
    .ramA_wdata (ramA_wdata),
    .ramB_wdata (ramB_wdata),
    .ramA_rdata (ramA_rdata),
    .ramB_rdata (ramB_rdata),
    .w_addr     (w_addr),
    .w_rdata    (w_rdata),
    .dbg_state  (dbg_state),
    .dbg_ld_cnt (dbg_ld_cnt),
    .dbg_rd_cnt (dbg_rd_cnt),
    .dbg_wr_cnt (dbg_wr_cnt),
    .dbg_w_cnt  (dbg_w_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory environment ----------------
  function automatic logic [319:0] rom_word(input logic [WAW-1:0] a);
    logic [31:0] h;
    h = 32'({22'd0, a}) * 32'h9e37_79b1;
    return {5{6'h2a, a, 16'hbeef ^ {6'd0, a}, h}};
  endfunction

  bit [63:0] mem_a [4096];
  bit [63:0] mem_b [4096];

  always @(posedge clk) begin
    if (ramA_we) mem_a[ramA_waddr] <= ramA_wdata;
    if (ramB_we) mem_b[ramB_waddr] <= ramB_wdata;
    ramA_rdata <= mem_a[ramA_raddr];
    ramB_rdata <= mem_b[ramB_raddr];
    w_rdata    <= rom_word(w_addr);
  end

  // ---------------- reference model / scoreboard ----------------
  int          vectors;
  int          miscompares;
  bit [63:0]   exp_a [4096];
  bit [63:0]   exp_b [4096];
  logic [127:0] exp_q[$];
  logic [319:0] exp_w;
  int          reads_in_stage, writes_in_stage, kern_total;
  bit          pend, pend_b;
  logic [AW-1:0] pend_addr;
  logic [63:0] frame [FW];

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    reads_in_stage  = 0;
    writes_in_stage = 0;
    kern_total      = 0;
    pend            = 1'b0;
    pend_b          = 1'b0;
    pend_addr       = '0;
    exp_w           = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_core();
    bus.mfsc_valid       = 1'b0;
    bus.mfsc_data        = '0;
    bus.Input_Require_WP = 1'b0;
    bus.Kernel_Require   = 1'b0;
    bus.Write_Require    = 1'b0;
    bus.Result_Ready     = 1'b0;
    bus.out_bus          = '0;
  endtask

  task automatic load_frame(input int gap_after);
    idle_core();
    for (int i = 0; i < FW; i++) begin
      bus.mfsc_valid = 1'b1;
      bus.mfsc_data  = frame[i];
      #2;
      check("ld_mfsc_ready", bus.mfsc_ready, 1'b1);
      check("ld_ramA_we", ramA_we, 1'b1);
      check("ld_ramA_waddr", ramA_waddr, AW'(i));
      check("ld_ramA_wdata", ramA_wdata, frame[i]);
      check("ld_start_early", bus.MFSC_Ready, 1'b0);
      exp_a[i] = frame[i];
      @(posedge clk); #1;
      if (i == gap_after) begin
        bus.mfsc_valid = 1'b0;
        bus.mfsc_data  = {$urandom, $urandom};
        #2;
        check("ld_gap_we", ramA_we, 1'b0);
        check("ld_gap_start", bus.MFSC_Ready, 1'b0);
        @(posedge clk); #1;
      end
    end
    bus.mfsc_valid = 1'b0;
    #2;
    check("start_pulse", bus.MFSC_Ready, 1'b1);
    check("start_mfsc_ready", bus.mfsc_ready, 1'b0);
    @(posedge clk); #1;
    #2;
    check("start_pulse_end", bus.MFSC_Ready, 1'b0);
    check("run_state", dbg_state, ST_RUN);
  endtask

  // One core cycle in RUN: drive requests, check this cycle's addresses/writes and
  // the data answering last cycle's requests, then advance the model.
  task automatic run_cycle(input logic [5:0] st, input logic [5:0] nst, input bit rd,
                           input bit k, input bit wr, input bit rr, input logic [63:0] ob);
    logic [127:0]  exp_rd;
    logic [AW-1:0] ra;
    bus.mfsc_valid       = 1'b0;
    bus.Stage            = st;
    bus.next_Stage       = nst;
    bus.Input_Require_WP = rd;
    bus.Kernel_Require   = k;
    bus.Write_Require    = wr;
    bus.Result_Ready     = rr;
    bus.out_bus          = ob;
    #2;
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("inA_bus", bus.inA_bus, exp_rd[63:0]);
    check("inB_bus", bus.inB_bus, exp_rd[127:64]);
    check("weight_bus", bus.weight_bus, exp_w);
    check("ramA_we", ramA_we, pend && !pend_b);
    check("ramB_we", ramB_we, pend && pend_b);
    if (st != nst) begin
      reads_in_stage  = 0;
      writes_in_stage = 0;
    end
    exp_w = '0;
    if (!rr && rd) begin
      ra = AW'(reads_in_stage);
      if (!nst[0]) check("ramA_raddr", ramA_raddr, ra);
      check("ramB_raddr", ramB_raddr, ra);
      exp_q.push_back({exp_b[ra], nst[0] ? exp_b[ra] : exp_a[ra]});
      reads_in_stage++;
    end
    if (!rr && k) begin
      check("w_addr", w_addr, WAW'(kern_total));
      exp_w = rom_word(WAW'(kern_total));
      kern_total++;
    end
    if (pend) begin
      if (pend_b) begin
        check("ramB_waddr", ramB_waddr, pend_addr);
        check("ramB_wdata", ramB_wdata, ob);
        exp_b[pend_addr] = ob;
      end else begin
        check("ramA_waddr", ramA_waddr, pend_addr);
        check("ramA_wdata", ramA_wdata, ob);
        exp_a[pend_addr] = ob;
      end
    end
    pend = wr && !rr;
    if (pend) begin
      pend_b    = !nst[0];
      pend_addr = AW'(writes_in_stage);
      writes_in_stage++;
    end
    if (rr) begin
      reads_in_stage  = 0;
      writes_in_stage = 0;
      kern_total      = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic random_run(inout logic [5:0] st, input int cycles);
    logic [5:0] nst;
    for (int c = 0; c < cycles; c++) begin
      nst = ($urandom_range(0, 7) == 0) ? st + 6'd1 : st;
      run_cycle(st, nst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom});
      st = nst;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [5:0]    st;
  bit            saved_b;
  logic [AW-1:0] saved_addr;

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    idle_core();
    bus.Stage      = '0;
    bus.next_Stage = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", dbg_state, ST_LOAD);
    check("rst_mfsc_ready", bus.mfsc_ready, 1'b1);
    check("rst_MFSC_Ready", bus.MFSC_Ready, 1'b0);
    check("rst_ramA_we", ramA_we, 1'b0);
    check("rst_ramB_we", ramB_we, 1'b0);
    check("rst_ramA_addrs", {ramA_waddr, ramA_raddr}, '0);
    check("rst_ramB_addrs", {ramB_waddr, ramB_raddr}, '0);
    check("rst_w_addr", w_addr, '0);
    check("rst_counters", {dbg_ld_cnt, dbg_rd_cnt, dbg_wr_cnt, dbg_w_cnt}, '0);
    check("rst_data_out", {bus.inA_bus, bus.inB_bus, bus.weight_bus}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    frame[0] = 64'h11; frame[1] = 64'h22; frame[2] = 64'h33; frame[3] = 64'h44;
    load_frame(1);

    // stage 0 reads with gaps
    run_cycle(6'd0, 6'd0, 1, 0, 0, 0, '0);
    run_cycle(6'd0, 6'd0, 0, 0, 0, 0, '0);
    run_cycle(6'd0, 6'd0, 1, 0, 0, 0, '0);
    run_cycle(6'd0, 6'd0, 1, 0, 0, 0, '0);
    run_cycle(6'd0, 6'd0, 0, 0, 0, 0, '0);

    // write straddling the 0 -> 1 boundary, then the first stage-1 write
    run_cycle(6'd0, 6'd0, 0, 0, 1, 0, 64'h1111_0000_0000_0001);
    run_cycle(6'd0, 6'd1, 0, 0, 0, 0, 64'hb0b0_0000_0000_00b0);
    run_cycle(6'd1, 6'd1, 0, 0, 1, 0, 64'h2222_0000_0000_0002);
    run_cycle(6'd1, 6'd1, 1, 0, 0, 0, 64'ha0a0_0000_0000_00a0);
    run_cycle(6'd1, 6'd1, 0, 0, 0, 0, '0);
    check("xfer_B0", mem_b[0], 64'hb0b0_0000_0000_00b0);
    check("xfer_A0", mem_a[0], 64'ha0a0_0000_0000_00a0);

    // kernels spanning a stage change
    run_cycle(6'd1, 6'd1, 0, 1, 0, 0, '0);
    run_cycle(6'd1, 6'd1, 0, 1, 0, 0, '0);
    run_cycle(6'd1, 6'd2, 0, 1, 0, 0, '0);
    run_cycle(6'd2, 6'd2, 0, 1, 0, 0, '0);
    run_cycle(6'd2, 6'd2, 0, 1, 0, 0, '0);
    run_cycle(6'd2, 6'd2, 0, 0, 0, 0, '0);

    st = 6'd2;
    random_run(st, 300);

    // completion returns to LOAD with counters cleared
    run_cycle(st, st, 0, 0, 0, 1, '0);
    idle_core();
    #1;
    check("rr_mfsc_ready", bus.mfsc_ready, 1'b1);
    check("rr_state", dbg_state, ST_LOAD);
    check("rr_counters", {dbg_ld_cnt, dbg_rd_cnt, dbg_wr_cnt, dbg_w_cnt}, '0);
    for (int i = 0; i < FW; i++) frame[i] = {$urandom, $urandom};
    load_frame(2);
    st = 6'd0;
    random_run(st, 60);

    // reset with a write pending: the write must be dropped
    run_cycle(st, st, 0, 0, 1, 0, {$urandom, $urandom});
    saved_b    = pend_b;
    saved_addr = pend_addr;
    bus.Write_Require = 1'b0;
    bus.out_bus       = 64'hdead_beef_dead_beef;
    rst = 1'b1;
    #1;
    check("abort_ramA_we", ramA_we, 1'b0);
    check("abort_ramB_we", ramB_we, 1'b0);
    check("abort_state", dbg_state, ST_LOAD);
    check("abort_counters", {dbg_ld_cnt, dbg_rd_cnt, dbg_wr_cnt, dbg_w_cnt}, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_ram_untouched", saved_b ? mem_b[saved_addr] : mem_a[saved_addr],
          saved_b ? exp_b[saved_addr] : exp_a[saved_addr]);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    for (int i = 0; i < FW; i++) frame[i] = {$urandom, $urandom};
    load_frame(0);
    st = 6'd5;
    random_run(st, 60);
    run_cycle(st, st, 0, 0, 0, 0, '0);
    run_cycle(st, st, 0, 0, 0, 0, '0);

    for (int i = 0; i < 32; i++) begin
      check("final_ram_a", mem_a[i], exp_a[i]);
      check("final_ram_b", mem_b[i], exp_b[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
